time_counter: RTL and testbench

Counting core of the stopwatch/timer datapath, driven directly by the mode controller's `init_ld_en`, `count_en`, `ctr_select` and `tc_select` strobes. It holds the elapsed/remaining time as four BCD digits (SS.hh, 00.00–99.99, 0–9999 hundredths) and advances them on a 100 Hz tick divided from the system clock. It loads a binary preset through a sequential binary-to-BCD converter. It reports the terminal-count flag and a load echo (`synch_init`) that the controller compares against its preset to know a load has landed. The display scanner downstream consumes `digits`.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/time_counter_if.sv | 36 +++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 rtl/time_counter.sv | 158 +++++++++++++++
 tb/tb_time_counter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared encodings, limits and BCD types for the stopwatch /
//                timer counting core.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    // ctr_select encodings driven by the mode controller
    localparam logic [2:0] CTR_LOAD_T  = 3'd0;
    localparam logic [2:0] CTR_UP      = 3'd1;
    localparam logic [2:0] CTR_DOWN    = 3'd2;
    localparam logic [2:0] CTR_LOAD_SW = 3'd3;

    // tc_select encodings
    localparam logic TC_UP   = 1'b0;   // terminal at MAX_VAL
    localparam logic TC_DOWN = 1'b1;   // terminal at zero

    // Upper count limit in hundredths (99.99 s)
    localparam int MAX_VAL = 9999;

    // Load echo reset value; no clamped preset can ever equal it, so the very
    // first load request is always seen as a change.
    localparam logic [16:0] SYNCH_INIT_RST = 17'h1FFFF;

    // Binary width fed to the converter (covers 0..9999) and its fixed latency
    localparam int CONV_BITS    = 14;
    localparam int CONV_LATENCY = 17;

    // One BCD digit and the four-digit display vector {tens-s, ones-s, tenths, hundredths}
    typedef logic [3:0]       bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd_vec_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/time_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_counter_if
//  Description : Strobe / result bundle between the mode controller (master)
//                and the time counting core (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface time_counter_if;
    import timer_pkg::*;

    // controller -> counter
    logic        init_ld_en;
    logic        count_en;
    logic [2:0]  ctr_select;
    logic        tc_select;
    logic [16:0] init_val;

    // counter -> controller / display scanner
    bcd_vec_t    digits;
    logic [16:0] count_bin;
    logic [16:0] synch_init;
    logic        load_busy;
    logic        tc_limit_reached;

    modport master (
        output init_ld_en, count_en, ctr_select, tc_select, init_val,
        input  digits, count_bin, synch_init, load_busy, tc_limit_reached
    );

    modport slave (
        input  init_ld_en, count_en, ctr_select, tc_select, init_val,
        output digits, count_bin, synch_init, load_busy, tc_limit_reached
    );

endinterface : time_counter_if
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter (4 digits).
//                One shift per cycle, padded to a fixed total latency so the
//                owner sees done exactly LATENCY-1 edges after start.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int LATENCY = 17
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             start,
    input  wire logic [BIN_W-1:0] bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           bcd_out
);

    localparam int SR_W  = 16 + BIN_W;
    localparam int CNT_W = $clog2(LATENCY);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_SHIFTS = CNT_W'(BIN_W);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SR_W-1:0]  sr_q,    sr_d;
    logic [SR_W-1:0]  sr_adj;

    // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift
    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
    for (genvar g = 0; g < 4; g++) begin : g_adj
        localparam int LSB = BIN_W + 4 * g;
        assign sr_adj[LSB +: 4] = (sr_q[LSB +: 4] >= 4'd5) ? (sr_q[LSB +: 4] + 4'd3)
                                                           : sr_q[LSB +: 4];
    end

    // Next-state: capture on start, shift BIN_W times, then idle out the padding
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                    sr_d    = {16'd0, bin_in};
                end
            end
            ST_CONV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_SHIFTS) begin
                        sr_d = {sr_adj[SR_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Converter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign busy    = (state_q == ST_CONV);
    assign done    = busy && (cnt_q == CNT_LAST);
    assign bcd_out = sr_q[SR_W-1 -: 16];

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : time_counter
//  Description : Stopwatch / timer counting core. Holds SS.hh as four BCD
//                digits with a binary mirror, counts up or down on a divided
//                tick with saturation, and loads a clamped binary preset
//                through a sequential binary-to-BCD converter.
//  Revision    : 1.0  initial release
// ============================================================================
module time_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_VAL = 9999
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    time_counter_if.slave  bus
);
    import timer_pkg::*;

    localparam int DIV_N = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;

    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_N - 1);
    localparam logic [16:0]      MAX_V    = 17'(MAX_VAL);

    logic [16:0]      clamp_val;
    logic             load_sel;
    logic             load_accept;
    logic             run_en;
    logic             tick;
    logic             conv_busy;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    bcd_vec_t         digits_q, digits_d;
    bcd_vec_t         inc_vec, dec_vec;
    logic             inc_carry, dec_borrow;
    logic [16:0]      count_bin_q, count_bin_d;
    logic [16:0]      synch_init_q, synch_init_d;
    logic [16:0]      load_val_q, load_val_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Load qualification: clamp the preset and accept only a changed value
    always_comb begin
        clamp_val   = (bus.init_val > MAX_V) ? MAX_V : bus.init_val;
        load_sel    = (bus.ctr_select == CTR_LOAD_T) || (bus.ctr_select == CTR_LOAD_SW);
        load_accept = bus.init_ld_en && load_sel && !conv_busy && (clamp_val != synch_init_q);
    end

    // Run qualification and tick at the divider terminal value
    always_comb begin
        run_en = bus.count_en && !conv_busy
              && ((bus.ctr_select == CTR_UP) || (bus.ctr_select == CTR_DOWN));
        tick   = run_en && (div_q == DIV_TERM);
    end

    bin2bcd_seq #(
        .BIN_W   (CONV_BITS),
        .LATENCY (CONV_LATENCY)
    ) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (load_accept),
        .bin_in  (clamp_val[CONV_BITS-1:0]),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    // Ripple BCD increment (9->0 carries) and decrement (0->9 borrows)
    always_comb begin
        inc_vec    = digits_q;
        dec_vec    = digits_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (digits_q[i] == 4'd9) begin
                    inc_vec[i] = 4'd0;
                end else begin
                    inc_vec[i] = digits_q[i] + 4'd1;
                    inc_carry  = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (digits_q[i] == 4'd0) begin
                    dec_vec[i] = 4'd9;
                end else begin
                    dec_vec[i] = digits_q[i] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    // Divider: cleared while a load is starting or converting, frozen when not running
    always_comb begin
        div_d = div_q;
        if (load_accept || conv_busy) begin
            div_d = '0;
        end else if (run_en) begin
            div_d = tick ? '0 : (div_q + DIV_W'(1));
        end
    end

    // Count update in priority order: load commit, load accept, tick, hold
    always_comb begin
        digits_d     = digits_q;
        count_bin_d  = count_bin_q;
        synch_init_d = synch_init_q;
        load_val_d   = load_val_q;
        if (conv_done) begin
            digits_d     = conv_bcd;
            count_bin_d  = load_val_q;
            synch_init_d = load_val_q;
        end else if (load_accept) begin
            load_val_d = clamp_val;
        end else if (tick) begin
            if ((bus.ctr_select == CTR_UP) && (count_bin_q != MAX_V)) begin
                digits_d    = inc_vec;
                count_bin_d = count_bin_q + 17'd1;
            end else if ((bus.ctr_select == CTR_DOWN) && (count_bin_q != '0)) begin
                digits_d    = dec_vec;
                count_bin_d = count_bin_q - 17'd1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q     <= '0;
            count_bin_q  <= '0;
            synch_init_q <= SYNCH_INIT_RST;
            load_val_q   <= '0;
            div_q        <= '0;
        end else begin
            digits_q     <= digits_d;
            count_bin_q  <= count_bin_d;
            synch_init_q <= synch_init_d;
            load_val_q   <= load_val_d;
            div_q        <= div_d;
        end
    end

    // Outputs; terminal count is combinational from the count register
    always_comb begin
        bus.digits           = digits_q;
        bus.count_bin        = count_bin_q;
        bus.synch_init       = synch_init_q;
        bus.load_busy        = conv_busy;
        bus.tc_limit_reached = (bus.tc_select == TC_DOWN) ? (count_bin_q == '0)
                                                          : (count_bin_q == MAX_V);
    end

endmodule : time_counter
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_time_counter
//  Description : Scoreboard bench for time_counter with an integer-level
//                reference model, directed boundary cases and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_counter;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIVN    = CLK_HZ / TICK_HZ;
    localparam int MAXV    = 9999;
    localparam int LOADLAT = 17;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    time_counter_if bus ();

    time_counter #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .MAX_VAL (MAXV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit resync   = 1'b1;

    typedef struct {
        int unsigned stamp;
        logic [15:0] dig;
        logic [16:0] bin;
        logic [16:0] echo;
    } exp_t;
    exp_t exp_q[$];

    // Reference state in plain integers
    int m_cnt, m_echo, m_pend, m_busy_left, m_div;

    function automatic logic [15:0] bcd_of(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_echo = 32'h1FFFF; m_pend = 0; m_busy_left = 0; m_div = 0;
    endtask

    // Advance the reference by one clock edge using the currently driven inputs
    task automatic model_edge();
        int  cv;
        int  prev;
        bit  commit;
        int  sel;
        sel    = int'(bus.ctr_select);
        cv     = (int'(bus.init_val) > MAXV) ? MAXV : int'(bus.init_val);
        prev   = m_cnt;
        commit = 1'b0;
        if (m_busy_left > 0) begin
            m_busy_left--;
            m_div = 0;
            if (m_busy_left == 0) begin
                m_cnt  = m_pend;
                m_echo = m_pend;
                commit = 1'b1;
            end
        end else if (bus.init_ld_en && (sel == 0 || sel == 3) && cv != m_echo) begin
            m_pend      = cv;
            m_busy_left = LOADLAT;
            m_div       = 0;
        end else if (bus.count_en && (sel == 1 || sel == 2)) begin
            if (m_div == DIVN - 1) begin
                m_div = 0;
                if (sel == 1) m_cnt = (m_cnt < MAXV) ? m_cnt + 1 : MAXV;
                else          m_cnt = (m_cnt > 0)    ? m_cnt - 1 : 0;
            end else begin
                m_div++;
            end
        end
        if (commit || m_cnt != prev)
            exp_q.push_back('{edge_no + 1, bcd_of(m_cnt), 17'(m_cnt), 17'(m_echo)});
    endtask

    // One clock: model, edge, then per-cycle status checks on the falling edge
    task automatic step();
        bit tc_exp;
        if (reset_n) model_edge();
        @(posedge clk);
        @(negedge clk);
        tc_exp = bus.tc_select ? (m_cnt == 0) : (m_cnt == MAXV);
        check("load_busy", 32'(bus.load_busy), 32'(m_busy_left > 0));
        check("tc_limit",  32'(bus.tc_limit_reached), 32'(tc_exp));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drive(input logic ld, input logic [2:0] sel, input logic en,
                         input logic tc, input int val);
        bus.init_ld_en = ld;
        bus.ctr_select = sel;
        bus.count_en   = en;
        bus.tc_select  = tc;
        bus.init_val   = 17'(val);
    endtask

    // Monitor: every commit or count change the DUT presents pops one expectation
    initial begin : monitor
        logic [15:0] pd;
        logic [16:0] pb;
        logic        pbusy;
        exp_t        e;
        pd = '0; pb = '0; pbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (resync || !reset_n) begin
                resync = 1'b0;
            end else if ((pbusy && !bus.load_busy) || bus.count_bin != pb || bus.digits != pd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: actual count_bin %0d digits %0h, required no change",
                             bus.count_bin, bus.digits);
                end else begin
                    e = exp_q.pop_front();
                    check("event_edge",  32'(edge_no),        32'(e.stamp));
                    check("event_digits", 32'(bus.digits),    32'(e.dig));
                    check("event_bin",   32'(bus.count_bin),  32'(e.bin));
                    check("event_echo",  32'(bus.synch_init), 32'(e.echo));
                end
            end
            pd    = bus.digits;
            pb    = bus.count_bin;
            pbusy = bus.load_busy;
        end
    end

    initial begin : stimulus
        int tmp;
        model_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_digits", 32'(bus.digits),     32'h0);
        check("rst_bin",    32'(bus.count_bin),  32'h0);
        check("rst_echo",   32'(bus.synch_init), 32'h1FFFF);
        check("rst_busy",   32'(bus.load_busy),  32'h0);
        reset_n = 1'b1;

        // Load 1234 and keep requesting: exactly one conversion
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1234);
        steps(30);
        check("load_1234_digits", 32'(bus.digits),     32'h1234);
        check("load_1234_echo",   32'(bus.synch_init), 32'd1234);

        // Clamp above the limit
        drive(1'b1, 3'd0, 1'b0, 1'b0, 12000);
        steps(20);
        check("clamp_digits", 32'(bus.digits),           32'h9999);
        check("clamp_echo",   32'(bus.synch_init),       32'd9999);
        check("clamp_tc",     32'(bus.tc_limit_reached), 32'h1);

        // Up count with carry into the hundreds digit
        drive(1'b1, 3'd3, 1'b1, 1'b0, 99);
        steps(20);
        drive(1'b0, 3'd1, 1'b1, 1'b0, 99);
        steps(DIVN);
        check("up_carry", 32'(bus.digits), 32'h0100);

        // Saturation at the top
        drive(1'b1, 3'd3, 1'b1, 1'b0, 9998);
        steps(20);
        drive(1'b0, 3'd1, 1'b1, 1'b0, 9998);
        steps(4 * DIVN);
        check("up_sat_digits", 32'(bus.digits),           32'h9999);
        check("up_sat_tc",     32'(bus.tc_limit_reached), 32'h1);

        // Down count with borrow, then saturation at zero
        drive(1'b1, 3'd3, 1'b1, 1'b1, 1000);
        steps(20);
        drive(1'b0, 3'd2, 1'b1, 1'b1, 1000);
        steps(DIVN);
        check("down_borrow", 32'(bus.digits), 32'h0999);
        drive(1'b1, 3'd0, 1'b1, 1'b1, 1);
        steps(20);
        drive(1'b0, 3'd2, 1'b1, 1'b1, 1);
        steps(3 * DIVN);
        check("down_sat_digits", 32'(bus.digits),           32'h0000);
        check("down_sat_tc",     32'(bus.tc_limit_reached), 32'h1);

        // Pause keeps the partial tick
        drive(1'b1, 3'd3, 1'b0, 1'b0, 500);
        steps(20);
        drive(1'b0, 3'd1, 1'b1, 1'b0, 500);
        steps(5);
        bus.count_en = 1'b0;
        steps(50);
        bus.count_en = 1'b1;
        steps(4);
        check("resume_hold", 32'(bus.digits), 32'h0500);
        step();
        check("resume_tick", 32'(bus.digits), 32'h0501);

        // Asynchronous reset in the middle of a conversion
        drive(1'b1, 3'd3, 1'b0, 1'b0, 4321);
        steps(8);
        #2;
        reset_n = 1'b0;
        resync  = 1'b1;
        #1;
        check("arst_busy",   32'(bus.load_busy),  32'h0);
        check("arst_digits", 32'(bus.digits),     32'h0);
        check("arst_bin",    32'(bus.count_bin),  32'h0);
        check("arst_echo",   32'(bus.synch_init), 32'h1FFFF);
        check("arst_queue",  32'(exp_q.size()),   32'h0);
        model_reset();
        @(negedge clk);
        steps(2);
        reset_n = 1'b1;
        steps(LOADLAT + 3);
        check("reload_digits", 32'(bus.digits),     32'h4321);
        check("reload_echo",   32'(bus.synch_init), 32'd4321);

        // Random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            tmp = int'($urandom_range(0, 9));
            bus.ctr_select = (tmp < 9) ? 3'(tmp % 4) : 3'($urandom_range(4, 7));
            bus.init_val   = ($urandom_range(0, 3) == 0) ? 17'($urandom_range(9990, 12000))
                                                         : 17'($urandom_range(0, 9999));
            bus.count_en   = ($urandom_range(0, 4) != 0);
            bus.init_ld_en = 1'($urandom_range(0, 1));
            bus.tc_select  = 1'($urandom_range(0, 1));
            steps(int'($urandom_range(3, 30)));
        end

        drive(1'b0, 3'd4, 1'b0, 1'b0, 0);
        steps(3);
        check("final_queue_empty", 32'(exp_q.size()),    32'h0);
        check("final_bin",         32'(bus.count_bin),   32'(m_cnt));
        check("final_digits",      32'(bus.digits),      32'(bcd_of(m_cnt)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_time_counter
`default_nettype wire
